// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
//
// Purpose:
//   WIDTH independent edge-detection channels. Each asynchronous input is
//   synchronized, then deglitched by a persistence filter. Accepted level
//   changes produce registered one-cycle edge pulses, gated per channel by
//   mode. Qualified pulses set sticky per-channel flags and are summed into
//   a saturating aggregate event counter.
//
// Parameters:
//   WIDTH        number of channels (1..32)
//   SYNC_STAGES  synchronizer depth per channel (2..4)
//   FILT_CYCLES  consecutive cycles a new level must persist (1..255)
//   CNT_W        width of the aggregate event counter
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous reset, active-low
//   din           asynchronous channel inputs
//   mode          per-channel select, bits [2i+1:2i]:
//                 00 off, 01 rising, 10 falling, 11 either
//   clr           per-channel sticky-flag clear (synchronous, active-high)
//   cnt_clr       event counter clear (synchronous, active-high)
//   rising_edge   one-cycle pulse per accepted 0->1 transition
//   falling_edge  one-cycle pulse per accepted 1->0 transition
//   either_edge   rising_edge | falling_edge
//   pend          sticky per-channel event flags
//   event_any     OR of all pend bits
//   edge_cnt      saturating count of qualified events, all channels
// -----------------------------------------------------------------------------
module multi_edge_detector #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   input  logic [2*WIDTH-1:0]   mode,
   input  logic [WIDTH-1:0]     clr,
   input  logic                 cnt_clr,
   output logic [WIDTH-1:0]     rising_edge,
   output logic [WIDTH-1:0]     falling_edge,
   output logic [WIDTH-1:0]     either_edge,
   output logic [WIDTH-1:0]     pend,
   output logic                 event_any,
   output logic [CNT_W-1:0]     edge_cnt
);

   // Sum width: wide enough for the counter plus one carry bit, and for a
   // popcount of up to 32 channels.
   localparam int                SUM_W     = ((CNT_W > 6) ? CNT_W : 6) + 1;
   localparam logic [7:0]        FILT_LAST = 8'(FILT_CYCLES - 1);
   localparam logic [SUM_W-1:0]  CNT_MAX   = SUM_W'({CNT_W{1'b1}});

   // --------------------------------------------------------------------------
   // Synchronizer chains; stage 0 samples din, last stage is the clean level.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // NOTE: every register here, including the array stages, is reset; the
   // asynchronous clear is part of the block's contract, not an afterthought.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int st = 0; st < SYNC_STAGES; st++) sync_q[st] <= '0;
      end else begin
         sync_q[0] <= din;
         for (int st = 1; st < SYNC_STAGES; st++) sync_q[st] <= sync_q[st-1];
      end
   end

   // --------------------------------------------------------------------------
   // Persistence filter. filt_cnt counts consecutive edges on which the
   // synchronized level disagrees with the accepted level; on the
   // FILT_CYCLES-th such edge the new level is accepted. filt_prev holds the
   // accepted level one cycle later so the pulse stage can see the change.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] filt_q;
   logic [WIDTH-1:0] filt_prev;
   logic [7:0]       filt_cnt [WIDTH];

   // NOTE: sequential state uses non-blocking assignment so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_q    <= '0;
         filt_prev <= '0;
         for (int i = 0; i < WIDTH; i++) filt_cnt[i] <= '0;
      end else begin
         filt_prev <= filt_q;
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_lvl[i] == filt_q[i]) begin
               filt_cnt[i] <= '0;
            end else if (filt_cnt[i] == FILT_LAST) begin
               filt_q[i]   <= sync_lvl[i];
               filt_cnt[i] <= '0;
            end else begin
               filt_cnt[i] <= filt_cnt[i] + 8'd1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Mode decode and pulse qualification. Mode is applied on the edge that
   // registers the pulse, so a later mode change never revives an old edge.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] rise_now;
   logic [WIDTH-1:0] fall_now;

   // NOTE: combinational blocks assign a default before any conditional
   // logic so no path leaves a variable holding its old value (no latches).
   always_comb begin
      rise_en = '0;
      fall_en = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rise_en[i] = mode[2*i];
         fall_en[i] = mode[2*i+1];
      end
   end

   assign rise_now = filt_q & ~filt_prev & rise_en;
   assign fall_now = ~filt_q & filt_prev & fall_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rising_edge  <= '0;
         falling_edge <= '0;
      end else begin
         rising_edge  <= rise_now;
         falling_edge <= fall_now;
      end
   end

   assign either_edge = rising_edge | falling_edge;

   // --------------------------------------------------------------------------
   // Sticky flags: the set term wins over a clear arriving in the pulse cycle.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pend <= '0;
      else      pend <= (pend & ~clr) | either_edge;
   end

   assign event_any = |pend;

   // --------------------------------------------------------------------------
   // Aggregate event counter: adds this cycle's pulse count and saturates.
   // cnt_clr restarts from zero but still counts the current cycle's events.
   // --------------------------------------------------------------------------
   logic [SUM_W-1:0] ev_num;
   logic [SUM_W-1:0] cnt_base;
   logic [SUM_W-1:0] cnt_sum;
   logic [SUM_W-1:0] cnt_next;

   always_comb begin
      ev_num = '0;
      for (int i = 0; i < WIDTH; i++) ev_num = ev_num + SUM_W'(either_edge[i]);
   end

   assign cnt_base = cnt_clr ? '0 : SUM_W'(edge_cnt);
   assign cnt_sum  = cnt_base + ev_num;
   assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX : cnt_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) edge_cnt <= '0;
      else      edge_cnt <= cnt_next[CNT_W-1:0];
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detector
//
// Directed bench for multi_edge_detector at WIDTH=4, SYNC_STAGES=2,
// FILT_CYCLES=3, CNT_W=8. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so the next rising edge is the first
// sampling edge k and a pulse is visible 6 ticks later (after edge k+5).
// -----------------------------------------------------------------------------
module tb_multi_edge_detector;

   logic       clk;
   logic       rst;
   logic [3:0] din;
   logic [7:0] mode;
   logic [3:0] clr;
   logic       cnt_clr;
   logic [3:0] rising_edge;
   logic [3:0] falling_edge;
   logic [3:0] either_edge;
   logic [3:0] pend;
   logic       event_any;
   logic [7:0] edge_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   multi_edge_detector #(
      .WIDTH       (4),
      .SYNC_STAGES (2),
      .FILT_CYCLES (3),
      .CNT_W       (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .mode         (mode),
      .clr          (clr),
      .cnt_clr      (cnt_clr),
      .rising_edge  (rising_edge),
      .falling_edge (falling_edge),
      .either_edge  (either_edge),
      .pend         (pend),
      .event_any    (event_any),
      .edge_cnt     (edge_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int         n_rise;
   int         n_fall;
   logic [3:0] seen;

   initial begin
      rst     = 1'b0;
      din     = 4'h0;
      mode    = 8'hFF;
      clr     = 4'h0;
      cnt_clr = 1'b0;

      // Reset state
      #12;
      check("rst_rising",    32'(rising_edge),  32'h0);
      check("rst_falling",   32'(falling_edge), 32'h0);
      check("rst_either",    32'(either_edge),  32'h0);
      check("rst_pend",      32'(pend),         32'h0);
      check("rst_event_any", 32'(event_any),    32'h0);
      check("rst_edge_cnt",  32'(edge_cnt),     32'h0);
      tick(1);
      rst = 1'b1;
      tick(2);

      // Single rising edge on channel 0, latency 5 edges, one-cycle pulse
      din = 4'b0001;
      tick(5);
      check("ch0_not_early", 32'(either_edge), 32'h0);
      tick(1);
      check("ch0_rising",    32'(rising_edge),  32'h1);
      check("ch0_either",    32'(either_edge),  32'h1);
      check("ch0_falling",   32'(falling_edge), 32'h0);
      tick(1);
      check("ch0_one_cycle", 32'(rising_edge),  32'h0);
      check("ch0_pend",      32'(pend),         32'h1);
      check("ch0_event_any", 32'(event_any),    32'h1);
      check("ch0_cnt",       32'(edge_cnt),     32'd1);
      tick(3);

      // 2-cycle glitch on channel 1 is filtered out
      din = din | 4'b0010;
      tick(2);
      din = din & 4'b1101;
      seen = 4'h0;
      repeat (8) begin
         tick(1);
         seen = seen | either_edge;
      end
      check("glitch_no_pulse", 32'(seen),     32'h0);
      check("glitch_pend",     32'(pend),     32'h1);
      check("glitch_cnt",      32'(edge_cnt), 32'd1);

      // Channel 2 in rising-only mode: rise reported, fall suppressed
      mode   = 8'hDF;
      din    = 4'b0101;
      n_rise = 0;
      n_fall = 0;
      repeat (6) begin
         tick(1);
         n_rise += int'(rising_edge[2]);
         n_fall += int'(falling_edge[2]);
      end
      din = 4'b0001;
      repeat (10) begin
         tick(1);
         n_rise += int'(rising_edge[2]);
         n_fall += int'(falling_edge[2]);
      end
      check("ch2_rise_count", 32'(n_rise),   32'd1);
      check("ch2_fall_count", 32'(n_fall),   32'd0);
      check("ch2_pend",       32'(pend),     32'h5);
      check("ch2_cnt",        32'(edge_cnt), 32'd2);

      // Clear all sticky flags
      clr = 4'hF;
      tick(1);
      clr = 4'h0;
      check("clr_pend",      32'(pend),      32'h0);
      check("clr_event_any", 32'(event_any), 32'h0);

      // All channels toggle together; clr[3] in the pulse cycle loses
      mode = 8'hFF;
      din  = 4'b1110;
      tick(5);
      check("all_not_early", 32'(either_edge), 32'h0);
      tick(1);
      check("all_either",  32'(either_edge),  32'hF);
      check("all_rising",  32'(rising_edge),  32'hE);
      check("all_falling", 32'(falling_edge), 32'h1);
      clr = 4'b1000;
      tick(1);
      clr = 4'h0;
      check("all_pend_set_wins", 32'(pend),     32'hF);
      check("all_cnt",           32'(edge_cnt), 32'd6);

      // Drive the counter to 254 in steps of 4, then saturate
      repeat (62) begin
         din = ~din;
         tick(6);
      end
      tick(2);
      check("cnt_254", 32'(edge_cnt), 32'd254);
      din = ~din;
      tick(8);
      check("cnt_sat", 32'(edge_cnt), 32'd255);
      din = ~din;
      tick(8);
      check("cnt_sat_hold", 32'(edge_cnt), 32'd255);

      // cnt_clr with two qualified events in the same cycle
      mode = 8'h0F;
      din  = ~din;
      tick(6);
      check("clr_cyc_either", 32'(either_edge), 32'h3);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      check("cnt_clr_load", 32'(edge_cnt), 32'd2);

      // Reset mid-filter clears everything immediately, without a clock edge
      mode = 8'hFF;
      din  = 4'hF;
      tick(3);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_rising", 32'(rising_edge),  32'h0);
      check("async_rst_either", 32'(either_edge),  32'h0);
      check("async_rst_pend",   32'(pend),         32'h0);
      check("async_rst_any",    32'(event_any),    32'h0);
      check("async_rst_cnt",    32'(edge_cnt),     32'd0);
      tick(3);
      check("in_rst_rising", 32'(rising_edge), 32'h0);

      // Inputs held high through reset report a rising edge after release
      rst = 1'b1;
      tick(5);
      check("rel_not_early", 32'(rising_edge), 32'h0);
      tick(1);
      check("rel_rising", 32'(rising_edge), 32'hF);
      tick(1);
      check("rel_one_cycle", 32'(rising_edge), 32'h0);
      check("rel_pend",      32'(pend),        32'hF);
      check("rel_cnt",       32'(edge_cnt),    32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel (2..4).
REQ-003 Parameter FILT_CYCLES, default 3: consecutive cycles a new level must persist before acceptance (1..255; 1 means no filtering).
REQ-004 Parameter CNT_W, default 8: width of the aggregate event counter.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 din  input  WIDTH  asynchronous channel inputs.
REQ-008 mode  input  2*WIDTH  per-channel select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 either.
REQ-009 clr  input  WIDTH  per-channel sticky-flag clear, active-high, synchronous.
REQ-010 cnt_clr  input  1  counter clear, active-high, synchronous.
REQ-011 rising_edge  output  WIDTH  one-cycle pulse per accepted 0->1 transition, gated by mode.
REQ-012 falling_edge  output  WIDTH  one-cycle pulse per accepted 1->0 transition, gated by mode.
REQ-013 either_edge  output  WIDTH  rising_edge | falling_edge per channel.
REQ-014 pend  output  WIDTH  sticky per-channel event flag.
REQ-015 event_any  output  1  OR of all pend bits, combinational from pend registers.
REQ-016 edge_cnt  output  CNT_W  saturating count of qualified events across all channels.

Function
REQ-017 Each channel SHALL pass din[i] through a SYNC_STAGES-deep flop chain; chain output is s[i].
REQ-018 Each channel SHALL hold a filtered level f[i] and a filter counter; counter resets to 0 whenever s[i]==f[i].
REQ-019 f[i] SHALL take the value of s[i] on the edge where s[i]!=f[i] has held for FILT_CYCLES consecutive sampling edges; counter returns to 0 on that edge.
REQ-020 A level shorter than FILT_CYCLES cycles at s[i] SHALL produce no change of f[i] and no pulse.
REQ-021 Edge pulses SHALL be registered: asserted for exactly one cycle, on the edge after f[i] changes.
REQ-022 Latency: a din level stable from sampling edge k SHALL produce its pulse at edge k+SYNC_STAGES+FILT_CYCLES, high for one cycle.
REQ-023 rising_edge[i] asserts only when mode[i] is 01 or 11; falling_edge[i] only when 10 or 11; mode 00 suppresses all pulses, pend set and counting, but filtering continues.
REQ-024 mode SHALL be sampled on the same edge that registers the pulse; no pulse is generated retroactively after a mode change.
REQ-025 pend[i] SHALL set on any qualified pulse of channel i and clear on clr[i]; simultaneous set and clear leaves pend[i]=1.
REQ-026 edge_cnt SHALL add the number of channels pulsing either_edge in the cycle (0..WIDTH) per edge.
REQ-027 edge_cnt SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-028 cnt_clr together with events SHALL load edge_cnt with that cycle's event count (saturated).
REQ-029 Channels SHALL be fully independent; simultaneous edges on all channels SHALL all be reported in the same cycle.

Reset
REQ-030 On rst=0, all synchronizer flops, f, filter counters, pulse outputs, pend and edge_cnt SHALL go to 0 immediately, independent of clk.
REQ-031 After rst release, a din[i] held at 1 SHALL be treated as a 0->1 transition and report a rising edge at normal latency if enabled.
REQ-032 Reset asserted mid-filter or mid-pulse SHALL abort it; no pulse appears after release for that aborted transition except per REQ-031.

Verification (WIDTH=4, SYNC_STAGES=2, FILT_CYCLES=3, CNT_W=8)
REQ-033 mode=11 all, din[0] 0->1 held 10 cycles -> rising_edge[0]=1, either_edge[0]=1 exactly one cycle, 5 edges after first sampling edge; pend[0]=1; edge_cnt=1.
REQ-034 din[1] high for 2 cycles, then low, mode=11 -> no pulse, pend[1]=0, edge_cnt unchanged.
REQ-035 mode[5:4]=01, din[2] rising then falling (each held 6 cycles) -> one rising_edge[2] pulse, no falling_edge[2]; edge_cnt +1.
REQ-036 All four din toggle same edge, mode=11 -> either_edge=4'hF in one cycle, edge_cnt +4; clr[3] asserted in that pulse cycle -> pend[3] remains 1.
REQ-037 edge_cnt preset to 254 via events, then 4 simultaneous events -> edge_cnt=255, stays 255; cnt_clr with 2 events same cycle -> edge_cnt=2.
REQ-038 din=4'hF during reset, release rst -> rising_edge=4'hF pulse at edge 5 after release; rst pulled low mid-filter -> all outputs 0 immediately.
